// File: rtl/spi_link_encoder.sv
// Command-to-byte-stream framer feeding an SPI shifter: WR_REG, RX_DATA (with body stream), SD_WRITE, SD_READ.
// Optional macro SPI_LINK_UNDERRUN_PAD_EN: pad a stalled RX_DATA body with 0x00 after 255 starved cycles.
module spi_link_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [6:0]  cmd_addr,
    input  logic [7:0]  cmd_data,
    input  logic [15:0] cmd_len,
    input  logic [7:0]  body_data,
    input  logic        body_valid,
    output logic        body_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  resp_data,
    output logic        resp_valid,
    output logic        busy,
    output logic        underrun
);

    localparam logic [1:0] OP_WR_REG   = 2'd0;
    localparam logic [1:0] OP_RX_DATA  = 2'd1;
    localparam logic [1:0] OP_SD_WRITE = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_OPCODE, S_ARG, S_HDR_LO, S_HDR_HI, S_BODY, S_DATA, S_DUMMY, S_WAIT_RESP
    } state_t;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [6:0]  r_addr;
    logic [7:0]  r_data;
    logic [15:0] r_len;
    logic [15:0] r_cnt;
    logic        r_last;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic [7:0]  r_resp_data;
    logic        r_resp_valid;

    logic        w_accept;
    logic        w_body_ready;
    logic        w_body_load;
    logic        w_pad_load;
    logic        w_load;
    logic [7:0]  w_load_byte;
    logic [7:0]  w_opcode;

    assign w_accept     = r_tx_valid && tx_ready;
    // r_last gate keeps the stream closed once the final body byte sits in the tx register
    assign w_body_ready = (r_state == S_BODY) && !r_last && (!r_tx_valid || tx_ready);
    assign w_body_load  = w_body_ready && body_valid;
    assign w_load       = w_body_load || w_pad_load;
    assign w_load_byte  = w_body_load ? body_data : 8'h00;
    assign w_opcode     = (cmd_op == OP_WR_REG)  ? 8'h87 :
                          (cmd_op == OP_RX_DATA) ? 8'h88 : 8'h89;

`ifdef SPI_LINK_UNDERRUN_PAD_EN
    logic [7:0] r_stall;
    logic       r_underrun;
    assign w_pad_load = w_body_ready && !body_valid && (r_stall == 8'd254);
    assign underrun   = r_underrun;
`else
    assign w_pad_load = 1'b0;
    assign underrun   = 1'b0;
`endif

    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign body_ready = w_body_ready;
    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign resp_data  = r_resp_data;
    assign resp_valid = r_resp_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_op         <= 2'd0;
            r_addr       <= 7'd0;
            r_data       <= 8'd0;
            r_len        <= 16'd0;
            r_cnt        <= 16'd0;
            r_last       <= 1'b0;
            r_tx_data    <= 8'd0;
            r_tx_valid   <= 1'b0;
            r_resp_data  <= 8'd0;
            r_resp_valid <= 1'b0;
`ifdef SPI_LINK_UNDERRUN_PAD_EN
            r_stall      <= 8'd0;
            r_underrun   <= 1'b0;
`endif
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op       <= cmd_op;
                        r_addr     <= cmd_addr;
                        r_data     <= cmd_data;
                        r_len      <= cmd_len;
                        r_cnt      <= 16'd0;
                        r_last     <= 1'b0;
                        r_tx_data  <= w_opcode;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_OPCODE;
`ifdef SPI_LINK_UNDERRUN_PAD_EN
                        r_stall    <= 8'd0;
                        r_underrun <= 1'b0;
`endif
                    end
                end
                S_OPCODE: begin
                    if (w_accept) begin
                        case (r_op)
                            OP_WR_REG: begin
                                r_tx_data <= r_data;
                                r_state   <= S_ARG;
                            end
                            OP_RX_DATA: begin
                                r_tx_data <= r_len[7:0];
                                r_state   <= S_HDR_LO;
                            end
                            OP_SD_WRITE: begin
                                r_tx_data <= {1'b1, r_addr};
                                r_state   <= S_ARG;
                            end
                            default: begin
                                r_tx_data <= {1'b0, r_addr};
                                r_state   <= S_ARG;
                            end
                        endcase
                    end
                end
                S_ARG: begin
                    if (w_accept) begin
                        if (r_op == OP_WR_REG) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= S_IDLE;
                        end else if (r_op == OP_SD_WRITE) begin
                            r_tx_data <= r_data;
                            r_state   <= S_DATA;
                        end else begin
                            r_tx_data <= 8'h00;
                            r_state   <= S_DUMMY;
                        end
                    end
                end
                S_HDR_LO: begin
                    if (w_accept) begin
                        r_tx_data <= r_len[15:8];
                        r_state   <= S_HDR_HI;
                    end
                end
                S_HDR_HI: begin
                    if (w_accept) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_BODY;
                    end
                end
                S_BODY: begin
                    if (w_load) begin
                        r_tx_data  <= w_load_byte;
                        r_tx_valid <= 1'b1;
                        // compare before increment so cmd_len=0xFFFF never wraps the counter
                        if (r_cnt == r_len) r_last <= 1'b1;
                        else r_cnt <= r_cnt + 16'd1;
`ifdef SPI_LINK_UNDERRUN_PAD_EN
                        r_stall <= 8'd0;
                        if (w_pad_load) r_underrun <= 1'b1;
`endif
                    end else begin
                        if (w_accept) begin
                            r_tx_valid <= 1'b0;
                            if (r_last) r_state <= S_IDLE;
                        end
`ifdef SPI_LINK_UNDERRUN_PAD_EN
                        if (w_body_ready) r_stall <= r_stall + 8'd1;
`endif
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                S_DUMMY: begin
                    if (w_accept) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    if (rx_valid) begin
                        r_resp_data  <= rx_data;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_link_encoder.md
SPI_LINK_ENCODER -- requirements
Module: spi_link_encoder

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all logic rising-edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports cmd_valid input 1, cmd_ready output 1, cmd_op input 2 (0=WR_REG, 1=RX_DATA, 2=SD_WRITE, 3=SD_READ), cmd_addr input 7, cmd_data input 8, cmd_len input 16 (body byte count minus one).
REQ-004 SHALL have ports body_data input 8, body_valid input 1, body_ready output 1 (RX_DATA body stream).
REQ-005 SHALL have ports tx_data output 8, tx_valid output 1, tx_ready input 1 (byte to SPI shifter), rx_data input 8, rx_valid input 1 (byte returned by shifter).
REQ-006 SHALL have ports resp_data output 8, resp_valid output 1, busy output 1, underrun output 1.

Function
REQ-007 Byte transfer SHALL occur on a cycle with tx_valid&&tx_ready; tx_data/tx_valid registered and held stable until accepted.
REQ-008 cmd_ready SHALL be 1 only in IDLE; command captured on cmd_valid&&cmd_ready; cmd_valid outside IDLE ignored.
REQ-009 tx_valid SHALL rise with the opcode byte the cycle after command capture (1-cycle latency).
REQ-010 Frames: WR_REG -> 0x87, cmd_data; RX_DATA -> 0x88, cmd_len[7:0], cmd_len[15:8], then cmd_len+1 body bytes; SD_WRITE -> 0x89, {1,cmd_addr}, cmd_data; SD_READ -> 0x89, {0,cmd_addr}, 0x00 dummy.
REQ-011 States SHALL be IDLE, OPCODE, ARG, HDR_LO, HDR_HI, BODY, DATA, DUMMY, WAIT_RESP; each byte state advances on acceptance of its byte; last byte accepted -> IDLE (WAIT_RESP for SD_READ).
REQ-012 body_ready SHALL equal (state==BODY)&&(!tx_valid||tx_ready); body byte loaded into tx register on body_valid&&body_ready.
REQ-013 Body counter SHALL be 16 bits, compared against captured cmd_len before increment; cmd_len=0xFFFF yields exactly 65536 bytes, cmd_len=0 exactly 1 byte.
REQ-014 Shifter contract: exactly one rx_valid per accepted byte, in order, before next byte accepted; rx_valid outside WAIT_RESP SHALL be ignored.
REQ-015 In WAIT_RESP first rx_valid SHALL load resp_data<=rx_data, pulse resp_valid one cycle, return to IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 Captured command fields SHALL not change mid-frame regardless of cmd_* inputs.

Reset
REQ-018 rst low SHALL immediately force IDLE, tx_valid=0, tx_data=0, resp_valid=0, resp_data=0, body_ready=0, underrun=0, counters=0; cmd_ready=1 after release.
REQ-019 Reset mid-frame SHALL abandon the partial frame; no pending byte or response emitted after release.

Configuration
REQ-020 With SPI_LINK_UNDERRUN_PAD_EN defined: 8-bit stall counter counts BODY cycles with body_ready=1 and body_valid=0; at 255 a 0x00 byte SHALL be inserted, counted as a body byte, underrun set sticky until next command capture; counter clears on every body byte loaded.
REQ-021 Without SPI_LINK_UNDERRUN_PAD_EN: BODY SHALL stall indefinitely awaiting body_valid; underrun tied 0.

Verification
REQ-022 WR_REG cmd_data=0x5A, tx_ready=1 -> tx bytes 0x87,0x5A on consecutive cycles, then IDLE, cmd_ready=1.
REQ-023 RX_DATA cmd_len=2, body 0x11,0x22,0x33 -> tx 0x88,0x02,0x00,0x11,0x22,0x33; body_ready drops after third byte.
REQ-024 SD_READ addr=0x05, shifter returns 0xC3 on dummy byte -> tx 0x89,0x05,0x00; resp_data=0xC3, one-cycle resp_valid.
REQ-025 SD_WRITE addr=0x12 data=0xA0 with tx_ready toggling every other cycle -> tx 0x89,0x92,0xA0, each held stable until accepted.
REQ-026 rst low during HDR_HI of RX_DATA -> tx_valid=0 same cycle; after release new WR_REG frame emitted cleanly.
REQ-027 With SPI_LINK_UNDERRUN_PAD_EN, RX_DATA cmd_len=0, body_valid held 0 -> 0x00 emitted after 255 stall cycles, underrun=1 until next command.
